multi_frame_buf: RTL
====================

// Module: multi_frame_buf
// PURPOSE
//  Single-clock N-deep frame buffer ring: writer fills whole frames into free banks, reader drains full banks oldest-first.
//  Next generation of the single-bank frame store; adds NUM_BUFS banks, ready/valid handshakes, frame-done strobes, occupancy count.
//  Sits between pixel source and display/processing pipeline; storage is one data_mem instance, address = {bank, word}.
// PARAMETERS
//  DATA_WIDTH  24               pixel word width
//  ADDR_WIDTH  3                word-address width within one bank
//  MEM_DEPTH   1<<ADDR_WIDTH    words per frame (1..2^ADDR_WIDTH); last word index MEM_DEPTH-1
//  NUM_BUFS    2                banks in the ring (>=1); BUF_W = max(1,$clog2(NUM_BUFS)) derived localparam
// PORTS
//  clk            in   1           single clock, all logic posedge
//  reset          in   1           asynchronous, active-low (`ASSERT = 1'b0)
//  wr_en_in       in   1           write request, active-low (`ASSERT)
//  data_in        in   DATA_WIDTH  write word
//  wr_rdy         out  1           1 = current write bank free, write accepted this cycle
//  wr_frame_done  out  1           1-cycle pulse: last word of a frame written
//  wr_drop        out  1           1-cycle pulse: wr_en_in asserted while wr_rdy=0 (word discarded)
//  rd_en_in       in   1           read request, active-low (`ASSERT)
//  rd_rdy         out  1           1 = at least one full bank
//  data_out       out  DATA_WIDTH  registered read word
//  rd_valid       out  1           data_out valid (1 cycle after accepted read)
//  rd_frame_done  out  1           pulse with rd_valid of last word of a frame
//  bufs_full      out  BUF_W+1     count of full banks, 0..NUM_BUFS
// BEHAVIOUR
//  Reset (async): wr_bank=rd_bank=0, wr_addr=rd_addr=0, bufs_full=0, wr_rdy=1, rd_rdy=0, data_out=0, all pulses/rd_valid=0.
//    Memory contents not cleared. Reset mid-frame abandons partial frames; nothing written before reset is readable after.
//  Write FSM {W_IDLE, W_FILL}: W_IDLE->W_FILL on accepted write (wr_addr=0); W_FILL->W_IDLE after word MEM_DEPTH-1.
//    Accept = wr_en_in==`ASSERT && wr_rdy; writes data_in to {wr_bank,wr_addr}; wr_addr+1.
//    Last word: wr_frame_done=1, bank marked full, wr_bank = (wr_bank==NUM_BUFS-1)?0:wr_bank+1, wr_addr=0.
//    Gaps (wr_en_in deasserted) in W_FILL hold position; no timeout.
//  Read FSM {R_IDLE, R_READ}: same structure on rd side; accept = rd_en_in==`ASSERT && rd_rdy.
//    Latency 1: data_out/rd_valid registered cycle after accept; rd_valid=0 when no accept (data_out holds).
//    Last word: rd_frame_done with its rd_valid; bank freed at accept of last word; rd_bank wraps as wr_bank.
//  bufs_full: +1 on write frame completion, -1 on read frame completion, unchanged if both same cycle.
//  wr_rdy = (bufs_full<NUM_BUFS) || W_FILL; rd_rdy = (bufs_full>0) || R_READ; both from registered state.
//  Newly completed frame visible to reader the following cycle (no same-cycle bypass).
//  Ring invariant: wr_bank==rd_bank only when bufs_full==0 or ==NUM_BUFS; NUM_BUFS=1 alternates fill/drain.
//  wr_drop: no state change, word lost. Read request while rd_rdy=0 ignored silently.
// CONFIGURATION
//  FRAME_BUF_OVERWRITE_EN defined: write at wr_addr=0 with bufs_full==NUM_BUFS and reader in R_IDLE discards oldest full bank
//    (rd_bank advances, bufs_full-1) and the write is accepted into it; wr_rdy=1 in that condition; no wr_drop.
//    If reader is in R_READ on that bank, writer stalls (wr_rdy=0) as without the macro.
//  Not defined: full ring always stalls writer; wr_drop pulses on every attempted write.
// STRUCTURE
//  Package frame_buf_pkg: `ASSERT/`DEASSERT, W_IDLE/W_FILL/R_IDLE/R_READ encodings, bank-wrap increment function.
//  Sub-module: existing data_mem, DATA_WIDTH, ADDR_WIDTH+BUF_W; no other sub-modules. Pointer/count logic inline.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=2, NUM_BUFS=2 unless noted)
//  Write 0x10..0x13 -> wr_frame_done on 4th; next cycle bufs_full=1, rd_rdy=1; read 4 -> data_out 0x10..0x13, rd_frame_done on 0x13, bufs_full=0.
//  Write 8 words, no reads -> bufs_full=2, wr_rdy=0; 9th write -> wr_drop=1, bufs_full stays 2, later reads return first frame intact.
//  bufs_full=1; reader's last word and writer's last word of bank1 same cycle -> bufs_full stays 1, next read returns bank1 data.
//  Reset low after 2 writes and 1 read -> all outputs reset values async; after release rd_rdy=0, first 4 writes land in bank0.
//  OVERWRITE_EN, ring full (frames A,B), R_IDLE, write frame C -> accepted, bufs_full=2, reads return B then C; without macro: wr_drop, reads A,B.
//  NUM_BUFS=3: write 3 frames, read 3, write/read 2 more -> banks wrap 2->0, data order preserved, bufs_full never >3.

Source files
------------

// File: rtl/multi_frame_buf_pkg.sv
// frame_buf_pkg: request polarity, FSM encodings and bank-ring helper shared by multi_frame_buf.
`define ASSERT 1'b0
`define DEASSERT 1'b1
package frame_buf_pkg;
    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_READ} r_state_t;
    function automatic int bank_inc(input int bank, input int num_bufs);
        return (bank == num_bufs - 1) ? 0 : bank + 1;
    endfunction
endpackage

// File: rtl/multi_frame_buf_data_mem.sv
// data_mem: word store with synchronous write and asynchronous read.
module data_mem #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/multi_frame_buf.sv
// multi_frame_buf: NUM_BUFS-bank frame ring; writer fills free banks, reader drains full banks oldest-first.
// Define FRAME_BUF_OVERWRITE_EN to let a blocked writer recycle the oldest full bank while the reader is idle.
module multi_frame_buf
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int MEM_DEPTH = 1 << ADDR_WIDTH,
    parameter int NUM_BUFS = 2,
    localparam int BUF_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  wr_rdy,
    output logic                  wr_frame_done,
    output logic                  wr_drop,
    input  logic                  rd_en_in,
    output logic                  rd_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  rd_frame_done,
    output logic [BUF_W:0]        bufs_full
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [BUF_W:0] FULL = (BUF_W + 1)'(NUM_BUFS);
    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;
    logic [BUF_W-1:0] wr_bank, rd_bank;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] mem_q;
    logic wr_acc, rd_acc, wr_last, rd_last, recycle;

`ifdef FRAME_BUF_OVERWRITE_EN
    // a read request claims the oldest bank first, so recycling yields to it
    assign recycle = bufs_full == FULL && w_state == W_IDLE && r_state == R_IDLE && rd_en_in != `ASSERT;
`else
    assign recycle = 1'b0;
`endif
    assign wr_rdy = bufs_full < FULL || w_state == W_FILL || recycle;
    assign rd_rdy = bufs_full != '0 || r_state == R_READ;
    assign wr_acc = wr_en_in == `ASSERT && wr_rdy;
    assign rd_acc = rd_en_in == `ASSERT && rd_rdy;
    assign wr_last = wr_addr == LAST;
    assign rd_last = rd_addr == LAST;
    assign wr_frame_done = wr_acc && wr_last;
    assign wr_drop = wr_en_in == `ASSERT && !wr_rdy;

    always_comb begin
        w_state_nx = w_state;
        r_state_nx = r_state;
        if (wr_acc) w_state_nx = wr_last ? W_IDLE : W_FILL;
        if (rd_acc) r_state_nx = rd_last ? R_IDLE : R_READ;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (reset == `ASSERT) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            wr_bank <= '0;
            rd_bank <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            bufs_full <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            rd_frame_done <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
            rd_valid <= rd_acc;
            rd_frame_done <= rd_acc && rd_last;
            bufs_full <= bufs_full + (BUF_W + 1)'(wr_frame_done)
                         - (BUF_W + 1)'((rd_acc && rd_last) || (recycle && wr_acc));
            if (wr_acc) begin
                wr_addr <= wr_last ? '0 : wr_addr + ADDR_WIDTH'(1);
                if (wr_last) wr_bank <= BUF_W'(bank_inc(int'(wr_bank), NUM_BUFS));
            end
            if (rd_acc) begin
                data_out <= mem_q;
                rd_addr <= rd_last ? '0 : rd_addr + ADDR_WIDTH'(1);
                if (rd_last) rd_bank <= BUF_W'(bank_inc(int'(rd_bank), NUM_BUFS));
            end else if (recycle && wr_acc) begin
                rd_bank <= BUF_W'(bank_inc(int'(rd_bank), NUM_BUFS));
            end
        end
    end

    data_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH + BUF_W)) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr ({wr_bank, wr_addr}),
        .wr_data (data_in),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_data (mem_q)
    );
endmodule
